mc_ctrl_fsm: RTL

//  Multicycle MIPS control FSM: decodes IR op/funct and drives datapath enables, mux selects and the 4-bit aluc consumed by ALU.

---
 rtl/mc_ctrl_fsm.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// mc_ctrl_fsm -- multicycle MIPS control FSM
//
// Decodes IR op/funct and steps each instruction through IF/ID/EX/MEM/WB,
// driving datapath enables, mux selects and the 4-bit ALU control. The state
// register is the only storage; every output is combinational in state, op,
// funct, z and mem_ready.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   op, funct         IR[31:26], IR[5:0]
//   z                 ALU zero flag, consumed by beq/bne in EX
//   mem_ready         unified memory finishes the access this cycle
//   mem_req/mem_write memory request / store qualifier
//   i_or_d            memory address select (0 PC, 1 ALUOut)
//   ir_write          load IR
//   pc_write, pc_src  load PC and its source (ALU, ALUOut, jump tgt, rs)
//   reg_write         register-file write enable
//   reg_dst           write register select (rt, rd, link_reg)
//   mem_to_reg        write data select (ALUOut, MDR, PC)
//   alu_src_a/_b      ALU operand selects
//   aluc              ALU operation code
//   link_reg          register number written by jal
//   state             current state (IF=0 ID=1 EX=2 MEM=3 WB=4)
//   retire            pulses in the last cycle of each instruction
//   illegal           pulses in ID on an undecoded op/funct
// ----------------------------------------------------------------------------
module mc_ctrl_fsm #(
   parameter logic [4:0] LINK_REG      = 5'd31,
   parameter bit         UNSIGNED_ALUC = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       z,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic [1:0] alu_src_a,
   output logic [2:0] alu_src_b,
   output logic [3:0] aluc,
   output logic [4:0] link_reg,
   output logic [2:0] state,
   output logic       retire,
   output logic       illegal
);

   // states
   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   // opcodes
   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct codes
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_SLLV = 6'b000100;
   localparam logic [5:0] F_SRLV = 6'b000110;
   localparam logic [5:0] F_SRAV = 6'b000111;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;

   // ALU codes
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   // Unsigned aliases the ALU treats identically to add/sub
   localparam logic [3:0] ALU_ADDU = UNSIGNED_ALUC ? 4'b1000 : ALU_ADD;
   localparam logic [3:0] ALU_SUBU = UNSIGNED_ALUC ? 4'b1100 : ALU_SUB;

   // operand selects
   localparam logic [1:0] A_PC    = 2'b00;
   localparam logic [1:0] A_RS    = 2'b01;
   localparam logic [1:0] A_SHAMT = 2'b10;
   localparam logic [2:0] B_RT    = 3'b000;
   localparam logic [2:0] B_FOUR  = 3'b001;
   localparam logic [2:0] B_SEXT  = 3'b010;
   localparam logic [2:0] B_SEXT2 = 3'b011;
   localparam logic [2:0] B_ZEXT  = 3'b100;

   logic [2:0] state_q, state_d;

   // ------------------------------------------------------------------
   // Instruction class decode
   // ------------------------------------------------------------------
   logic is_rtype, r_alu, r_shamt, is_jr, is_j, is_jal;
   logic is_beq, is_bne, is_lw, is_sw, i_alu, i_zext, legal;
   logic [3:0] alu_op;

   always_comb begin
      is_rtype = (op == OP_R);
      r_alu    = 1'b0;
      r_shamt  = 1'b0;
      if (is_rtype) begin
         case (funct)
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR,
            F_SLLV, F_SRLV, F_SRAV: r_alu = 1'b1;
            F_SLL, F_SRL, F_SRA: begin
               r_alu   = 1'b1;
               r_shamt = 1'b1;
            end
            default: r_alu = 1'b0;
         endcase
      end
      is_jr  = is_rtype && (funct == F_JR);
      is_j   = (op == OP_J);
      is_jal = (op == OP_JAL);
      is_beq = (op == OP_BEQ);
      is_bne = (op == OP_BNE);
      is_lw  = (op == OP_LW);
      is_sw  = (op == OP_SW);
      i_zext = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
      i_alu  = i_zext || (op == OP_ADDI) || (op == OP_ADDIU);
      legal  = r_alu || is_jr || is_j || is_jal || is_beq || is_bne ||
               i_alu || is_lw || is_sw;
   end

   // ALU operation for the EX step of ALU-class instructions
   always_comb begin
      alu_op = ALU_ADD;
      if (is_rtype) begin
         case (funct)
            F_ADDU:         alu_op = ALU_ADDU;
            F_SUB:          alu_op = ALU_SUB;
            F_SUBU:         alu_op = ALU_SUBU;
            F_AND:          alu_op = ALU_AND;
            F_OR:           alu_op = ALU_OR;
            F_XOR:          alu_op = ALU_XOR;
            F_SLL, F_SLLV:  alu_op = ALU_SLL;
            F_SRL, F_SRLV:  alu_op = ALU_SRL;
            F_SRA, F_SRAV:  alu_op = ALU_SRA;
            default:        alu_op = ALU_ADD;
         endcase
      end else begin
         case (op)
            OP_ADDIU: alu_op = ALU_ADDU;
            OP_ANDI:  alu_op = ALU_AND;
            OP_ORI:   alu_op = ALU_OR;
            OP_XORI:  alu_op = ALU_XOR;
            OP_LUI:   alu_op = ALU_LUI;
            default:  alu_op = ALU_ADD;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_a  = A_PC;
      alu_src_b  = B_RT;
      aluc       = ALU_ADD;
      retire     = 1'b0;
      illegal    = 1'b0;

      // In reset everything stays at its default so an aborted
      // instruction cannot commit anything in that cycle.
      if (!rst) begin
         case (state_q)
            S_IF: begin
               mem_req   = 1'b1;
               alu_src_b = B_FOUR;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_ID;
               end
            end

            S_ID: begin
               // Branch target computed speculatively into ALUOut.
               alu_src_b = B_SEXT2;
               state_d   = S_EX;
               if (is_j || is_jal) begin
                  pc_write = 1'b1;
                  pc_src   = 2'b10;
                  retire   = 1'b1;
                  state_d  = S_IF;
                  if (is_jal) begin
                     // PC already holds PC+4, i.e. the return address.
                     reg_write  = 1'b1;
                     reg_dst    = 2'b10;
                     mem_to_reg = 2'b10;
                  end
               end else if (is_jr) begin
                  pc_write = 1'b1;
                  pc_src   = 2'b11;
                  retire   = 1'b1;
                  state_d  = S_IF;
               end else if (!legal) begin
                  illegal = 1'b1;
                  state_d = S_IF;
               end
            end

            S_EX: begin
               state_d = S_IF;
               if (r_alu) begin
                  alu_src_a = r_shamt ? A_SHAMT : A_RS;
                  alu_src_b = B_RT;
                  aluc      = alu_op;
                  state_d   = S_WB;
               end else if (i_alu) begin
                  alu_src_a = A_RS;
                  alu_src_b = i_zext ? B_ZEXT : B_SEXT;
                  aluc      = alu_op;
                  state_d   = S_WB;
               end else if (is_lw || is_sw) begin
                  alu_src_a = A_RS;
                  alu_src_b = B_SEXT;
                  state_d   = S_MEM;
               end else if (is_beq || is_bne) begin
                  alu_src_a = A_RS;
                  alu_src_b = B_RT;
                  aluc      = ALU_SUB;
                  pc_write  = is_beq ? z : ~z;
                  pc_src    = 2'b01;
                  retire    = 1'b1;
               end
            end

            S_MEM: begin
               mem_req   = 1'b1;
               i_or_d    = 1'b1;
               mem_write = is_sw;
               if (mem_ready) begin
                  if (is_sw) begin
                     retire  = 1'b1;
                     state_d = S_IF;
                  end else begin
                     state_d = S_WB;
                  end
               end
            end

            S_WB: begin
               reg_write  = 1'b1;
               reg_dst    = is_rtype ? 2'b01 : 2'b00;
               mem_to_reg = is_lw ? 2'b01 : 2'b00;
               retire     = 1'b1;
               state_d    = S_IF;
            end

            default: state_d = S_IF;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IF;
      else     state_q <= state_d;
   end

   assign state    = state_q;
   assign link_reg = LINK_REG;

endmodule
